// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. A fetch hits in one cycle;
// a miss is filled from the memory controller, and a redirect discards the result.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ok,
  output logic [31:0] if_ans,
  output logic        mem_read_inst,
  output logic [31:0] mem_read_inst_addr,
  input  logic [31:0] mem_read_inst_ans,
  input  logic        mem_read_inst_ok
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [31:0]           words [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  addr_lo_unused;

  // The outstanding miss address doubles as the fill target.
  always_comb begin
    req_idx  = if_addr[INDEX_BITS+1:2];
    req_tag  = if_addr[31:INDEX_BITS+2];
    fill_idx = mem_read_inst_addr[INDEX_BITS+1:2];
    fill_tag = mem_read_inst_addr[31:INDEX_BITS+2];
    hit      = valid[req_idx] && (tags[req_idx] == req_tag);
  end

  assign addr_lo_unused = ^if_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      valid              <= '0;
      if_ok              <= 1'b0;
      if_ans             <= '0;
      mem_read_inst      <= 1'b0;
      mem_read_inst_addr <= '0;
    end else if (rdy) begin
      if_ok <= 1'b0;
      case (state)
        IDLE: begin
          // if_ok high means the request on if_req was just served.
          if (if_req && !if_flush && !if_ok) begin
            if (hit) begin
              if_ok  <= 1'b1;
              if_ans <= words[req_idx];
            end else begin
              mem_read_inst      <= 1'b1;
              mem_read_inst_addr <= {if_addr[31:2], 2'b00};
              state              <= MISS;
            end
          end
        end
        MISS, DROP: begin
          if (mem_read_inst_ok) begin
            valid[fill_idx] <= 1'b1;
            tags[fill_idx]  <= fill_tag;
            words[fill_idx] <= mem_read_inst_ans;
            mem_read_inst   <= 1'b0;
            state           <= IDLE;
            if (state == MISS && !if_flush) begin
              if_ok  <= 1'b1;
              if_ans <= mem_read_inst_ans;
            end
          end else if (if_flush) begin
            state <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, sets the number of direct-mapped one-word lines to 2^INDEX_BITS.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rdy  in  1  global enable; 0 freezes all state and outputs.
REQ-005 if_req  in  1  fetch request from the fetch stage, level.
REQ-006 if_addr  in  32  fetch address, word-aligned; bits [1:0] are ignored.
REQ-007 if_flush  in  1  fetch redirect; discards any outstanding request.
REQ-008 if_ok  out  1  one-cycle pulse; if_ans is valid.
REQ-009 if_ans  out  32  instruction word.
REQ-010 mem_read_inst  out  1  read request to the memory controller.
REQ-011 mem_read_inst_addr  out  32  word address sent to the memory controller.
REQ-012 mem_read_inst_ans  in  32  memory controller read data.
REQ-013 mem_read_inst_ok  in  1  memory controller one-cycle completion pulse.

Function
REQ-014 Address split: index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2]; each line holds valid, tag and a 32-bit word.
REQ-015 States: IDLE, MISS, DROP; the state register, line storage and all outputs are registered.
REQ-016 IDLE accepts a request when if_req=1, if_flush=0 and if_ok=0; a request seen while if_ok=1 is the just-served request and is ignored.
REQ-017 Hit in IDLE (valid and tag match): the next cycle shows if_ok=1 and if_ans=line data; state stays IDLE; 1-cycle latency.
REQ-018 Miss in IDLE: the next cycle shows mem_read_inst=1 and mem_read_inst_addr={if_addr[31:2],2'b00}; the address is latched internally; state becomes MISS.
REQ-019 In MISS and DROP, mem_read_inst and mem_read_inst_addr are held constant until mem_read_inst_ok, because the memory controller re-reads the address every step.
REQ-020 MISS with mem_read_inst_ok=1: write the line (valid=1, tag, data); next cycle if_ok=1, if_ans=mem_read_inst_ans, mem_read_inst=0; state becomes IDLE.
REQ-021 if_flush=1 in MISS: the memory read is not aborted; state becomes DROP.
REQ-022 DROP with mem_read_inst_ok=1: fill the line; if_ok stays 0; mem_read_inst drops to 0; state becomes IDLE.
REQ-023 if_flush and mem_read_inst_ok in the same MISS cycle: the line is filled, if_ok stays 0, state becomes IDLE.
REQ-024 if_flush=1 in IDLE: no request is accepted that cycle, and a hit pulse registered for that cycle is suppressed.
REQ-025 if_ok is high for exactly one cycle per served request and is never high while state is MISS or DROP.
REQ-026 mem_read_inst falls in the cycle after mem_read_inst_ok; the controller's rest cycle absorbs this.
REQ-027 mem_read_inst_ok arriving in IDLE is ignored and causes no line write.
REQ-028 rdy=0: state, lines and outputs hold; an ok pulse arriving while rdy=0 is lost, because the memory controller is frozen by the same rdy.

Reset
REQ-029 With rst=1 at a clock edge: all valid bits=0, state=IDLE, if_ok=0, if_ans=0, mem_read_inst=0, mem_read_inst_addr=0.
REQ-030 Reset mid-MISS abandons the fill: no line is written and no if_ok follows.
REQ-031 rst has priority over rdy.

Verification
REQ-032 Cold miss: if_req=1, if_addr=0x1004 -> mem_read_inst=1 at 0x1004; memory returns 0x00A00093 -> one if_ok pulse with if_ans=0x00A00093.
REQ-033 Hit after fill: request 0x1004 again -> if_ok the next cycle with 0x00A00093 and no mem_read_inst.
REQ-034 Conflict: INDEX_BITS=6, fill 0x1004, then request 0x1104 (same index, different tag) -> miss; afterwards 0x1004 misses again.
REQ-035 Flush during miss: if_flush pulse 2 cycles after the miss at 0x2000 -> mem_read_inst stays high until ok; no if_ok; a later 0x2000 request hits.
REQ-036 rdy=0 for 3 cycles mid-MISS -> outputs frozen; after rdy=1 the fill completes normally.
REQ-037 Reset mid-MISS, then request 0x1004 -> miss; all lines invalid.
